sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter N_SPRITES, 5: number of sprite slots; slot 0 is the player.
REQ-002 Parameter TILE_SIZE, 32: sprite edge in pixels, power of two; TB = log2(TILE_SIZE).
REQ-003 Parameter IMG_BITS, 2: width of per-slot image index into sprite memory.
REQ-004 Parameter TRANSPARENT, 9'h000: colour key; sprite pixels equal to it show background.
REQ-005 Parameters H_VISIBLE_AREA 640, V_VISIBLE_AREA 480, H_TOTAL 800, V_TOTAL 525, H_FRONT_PORCH 16, H_SYNC_PULSE 96, V_FRONT_PORCH 10, V_SYNC_PULSE 2: VGA timing.
REQ-006 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-007 i_Clk  in  1  pixel clock.
REQ-008 i_Reset  in  1  asynchronous active-high reset.
REQ-009 i_Sprite_X  in  N_SPRITES*10  packed left-edge X, slot k at [10k+9:10k].
REQ-010 i_Sprite_Y  in  N_SPRITES*9  packed top-edge Y, slot k at [9k+8:9k].
REQ-011 i_Sprite_En  in  N_SPRITES  per-slot enable.
REQ-012 i_Sprite_Img  in  N_SPRITES*IMG_BITS  per-slot image index.
REQ-013 i_Bg_Color  in  9  background RGB333.
REQ-014 o_Rom_Addr  out  IMG_BITS+2*TB  sprite memory address; memory is synchronous, 1-cycle read latency.
REQ-015 i_Rom_Data  in  9  RGB333 returned one clock after o_Rom_Addr.
REQ-016 o_VGA_HSync, o_VGA_VSync  out  1 each  active-low syncs.
REQ-017 o_VGA_Red, o_VGA_Grn, o_VGA_Blu  out  3 each  colour.
REQ-018 o_Frame_Start  out  1  one-cycle pulse at frame wrap.
REQ-019 o_Collision  out  N_SPRITES-1  bit k-1 set if slot 0 overlapped slot k in previous frame.

Function
REQ-020 h counter SHALL count 0..H_TOTAL-1 then wrap; v counter SHALL advance on h wrap, 0..V_TOTAL-1, then wrap.
REQ-021 At the cycle the counters go (H_TOTAL-1,V_TOTAL-1)->(0,0), X/Y/En/Img SHALL be latched into shadow registers; all drawing uses shadows only (no mid-frame tearing).
REQ-022 o_Frame_Start SHALL pulse high for exactly that wrap cycle.
REQ-023 Stage 1: slot k hits if En and X<=h<X+TILE_SIZE and Y<=v<Y+TILE_SIZE, compared at 11 bits (no wrap for sprites crossing right/bottom edge).
REQ-024 Lowest-index hitting slot SHALL win; o_Rom_Addr registered as {Img, v-Y (TB bits), h-X (TB bits)}; no hit -> address unchanged.
REQ-025 Stage 2: winner flag and visible flag pipelined alongside memory read.
REQ-026 Stage 3: RGB registered = 0 if not visible; i_Bg_Color if no winner or i_Rom_Data==TRANSPARENT; else i_Rom_Data.
REQ-027 Sync SHALL be low for H_VISIBLE_AREA+H_FRONT_PORCH <= h < +H_SYNC_PULSE (V likewise), delayed so sync and RGB for counter value (h,v) both appear 3 clocks after counters hold (h,v).
REQ-028 Pixels with h>=H_VISIBLE_AREA or v>=V_VISIBLE_AREA SHALL output RGB 0 regardless of sprite hits.
REQ-029 Collision accumulator bit k-1 SHALL set on any visible pixel where slot 0 and slot k both hit (box overlap, ignores transparency).
REQ-030 At frame wrap o_Collision SHALL load accumulator and accumulator SHALL clear same cycle; a hit on the wrap pixel counts toward the new frame.
REQ-031 Disabled slots SHALL neither draw nor collide.

Reset
REQ-032 On i_Reset high: counters 0, shadows 0 (all slots disabled), o_Rom_Addr 0, RGB 0, syncs 1, o_Frame_Start 0, o_Collision 0, pipeline flags 0; asserting mid-frame SHALL take effect immediately.
REQ-033 After release, the first frame starts at (0,0) without o_Frame_Start; first pulse at first wrap.

Verification
REQ-034 Reset release, all En=0, Bg=9'h1C7 -> visible pixels 9'h1C7, blanking 0; HSync low 96 clocks/line starting output clock 656+3; VSync low lines 490-491.
REQ-035 Slot 0 at (100,50), Img 1, ROM returns addr value -> pixel (100+c,50+r) colour equals ROM at {1,r,c}; latency exactly 3 clocks.
REQ-036 Slots 0 and 2 both at (200,200) -> slot 0 drawn; o_Collision=4'b0010 after next wrap, cleared one frame after slot 2 moved away.
REQ-037 Slot 1 at X=630,Y=470 -> columns 630-639, rows 470-479 drawn, nothing wraps to X<32 or Y<32.
REQ-038 Change i_Sprite_X mid-frame -> image unchanged until next o_Frame_Start; ROM returning TRANSPARENT -> i_Bg_Color shown.
REQ-039 Assert i_Reset mid-line -> outputs at REQ-032 values asynchronously, clean frame after release.

Source files
------------

// File: rtl/sprite_compositor.sv
// Sprite compositor: VGA timing, per-frame shadowed sprite slots, 3-stage pixel
// pipeline against a synchronous sprite memory, and player collision reporting.
module sprite_compositor #(
  parameter int unsigned N_SPRITES      = 5,
  parameter int unsigned TILE_SIZE      = 32,
  parameter int unsigned IMG_BITS       = 2,
  parameter logic [8:0]  TRANSPARENT    = 9'h000,
  parameter int unsigned H_VISIBLE_AREA = 640,
  parameter int unsigned V_VISIBLE_AREA = 480,
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned V_TOTAL        = 525,
  parameter int unsigned H_FRONT_PORCH  = 16,
  parameter int unsigned H_SYNC_PULSE   = 96,
  parameter int unsigned V_FRONT_PORCH  = 10,
  parameter int unsigned V_SYNC_PULSE   = 2,
  localparam int unsigned TB            = $clog2(TILE_SIZE),
  localparam int unsigned AW            = IMG_BITS + 2 * TB
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset,
  input  logic [N_SPRITES*10-1:0]       i_Sprite_X,
  input  logic [N_SPRITES*9-1:0]        i_Sprite_Y,
  input  logic [N_SPRITES-1:0]          i_Sprite_En,
  input  logic [N_SPRITES*IMG_BITS-1:0] i_Sprite_Img,
  input  logic [8:0]                    i_Bg_Color,
  output logic [AW-1:0]                 o_Rom_Addr,
  input  logic [8:0]                    i_Rom_Data,
  output logic                          o_VGA_HSync,
  output logic                          o_VGA_VSync,
  output logic [2:0]                    o_VGA_Red,
  output logic [2:0]                    o_VGA_Grn,
  output logic [2:0]                    o_VGA_Blu,
  output logic                          o_Frame_Start,
  output logic [N_SPRITES-2:0]          o_Collision
);

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS  = 10'(H_VISIBLE_AREA);
  localparam logic [9:0]  V_VIS  = 10'(V_VISIBLE_AREA);
  localparam logic [9:0]  HS_BEG = 10'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [9:0]  HS_END = 10'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [9:0]  VS_BEG = 10'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [9:0]  VS_END = 10'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);
  localparam logic [10:0] TILE_E = 11'(TILE_SIZE);

  logic [9:0]                    h_q, h_d, v_q, v_d;
  logic                          wrap_c, vis_c, hs_c, vs_c, win_c;
  logic [N_SPRITES*10-1:0]       x_q;
  logic [N_SPRITES*9-1:0]        y_q;
  logic [N_SPRITES-1:0]          en_q, hit_c;
  logic [N_SPRITES*IMG_BITS-1:0] img_q;
  logic [10:0]                   dx_c [N_SPRITES];
  logic [10:0]                   dy_c [N_SPRITES];
  logic [AW-1:0]                 rom_addr_q, addr_d;
  logic                          win1_q, vis1_q, win2_q, vis2_q, fs_q;
  logic [2:0]                    hs_q, vs_q;
  logic [8:0]                    rgb_q, rgb_d;
  logic [N_SPRITES-2:0]          coll_c, coll_acc_q, coll_acc_d, coll_q;

  // Raster counters
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
  end

  assign wrap_c = (h_q == H_LAST) && (v_q == V_LAST);
  assign vis_c  = (h_q < H_VIS) && (v_q < V_VIS);
  assign hs_c   = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_c   = !((v_q >= VS_BEG) && (v_q < VS_END));

  // 11-bit offsets: a negative offset sets bit 10 and so fails the tile bound
  for (genvar g = 0; g < N_SPRITES; g++) begin : g_slot
    assign dx_c[g]  = {1'b0, h_q} - {1'b0, x_q[g*10 +: 10]};
    assign dy_c[g]  = {1'b0, v_q} - {2'b0, y_q[g*9 +: 9]};
    assign hit_c[g] = en_q[g] && (dx_c[g] < TILE_E) && (dy_c[g] < TILE_E);
  end

  for (genvar g = 1; g < N_SPRITES; g++) begin : g_coll
    assign coll_c[g-1] = vis_c && hit_c[0] && hit_c[g];
  end

  assign coll_acc_d = (wrap_c ? '0 : coll_acc_q) | coll_c;

  // Lowest-index hit wins the memory address
  always_comb begin
    win_c  = 1'b0;
    addr_d = rom_addr_q;
    for (int k = 0; k < N_SPRITES; k++) begin
      if (hit_c[k] && !win_c) begin
        win_c  = 1'b1;
        addr_d = {img_q[k*IMG_BITS +: IMG_BITS], dy_c[k][TB-1:0], dx_c[k][TB-1:0]};
      end
    end
  end

  always_comb begin
    rgb_d = i_Rom_Data;
    if (!vis2_q) begin
      rgb_d = '0;
    end else if (!win2_q || (i_Rom_Data == TRANSPARENT)) begin
      rgb_d = i_Bg_Color;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      h_q        <= '0;
      v_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      en_q       <= '0;
      img_q      <= '0;
      rom_addr_q <= '0;
      win1_q     <= 1'b0;
      vis1_q     <= 1'b0;
      win2_q     <= 1'b0;
      vis2_q     <= 1'b0;
      rgb_q      <= '0;
      hs_q       <= '1;
      vs_q       <= '1;
      fs_q       <= 1'b0;
      coll_acc_q <= '0;
      coll_q     <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      fs_q       <= wrap_c;
      if (wrap_c) begin
        x_q    <= i_Sprite_X;
        y_q    <= i_Sprite_Y;
        en_q   <= i_Sprite_En;
        img_q  <= i_Sprite_Img;
        coll_q <= coll_acc_q;
      end
      coll_acc_q <= coll_acc_d;
      rom_addr_q <= addr_d;
      win1_q     <= win_c;
      vis1_q     <= vis_c;
      win2_q     <= win1_q;
      vis2_q     <= vis1_q;
      rgb_q      <= rgb_d;
      hs_q       <= {hs_q[1:0], hs_c};
      vs_q       <= {vs_q[1:0], vs_c};
    end
  end

  assign o_Rom_Addr    = rom_addr_q;
  assign o_VGA_HSync   = hs_q[2];
  assign o_VGA_VSync   = vs_q[2];
  assign o_VGA_Red     = rgb_q[8:6];
  assign o_VGA_Grn     = rgb_q[5:3];
  assign o_VGA_Blu     = rgb_q[2:0];
  assign o_Frame_Start = fs_q;
  assign o_Collision   = coll_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor on a reduced raster; captures whole output frames
// indexed by pixel and checks them against hand-computed colours.
module tb_sprite_compositor;

  localparam int unsigned NS = 5, TS = 8, IB = 2;
  localparam int unsigned HV = 48, HFP = 4, HSP = 8, HT = 64;
  localparam int unsigned VV = 32, VFP = 2, VSP = 2, VT = 40;
  localparam int F  = HT * VT;
  localparam int AW = IB + 6;
  localparam int NV = 26;
  localparam logic [8:0] BG   = 9'h1C7;
  localparam logic [7:0] TKEY = 8'h53;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NS*10-1:0]  sx;
  logic [NS*9-1:0]   sy;
  logic [NS-1:0]     sen;
  logic [NS*IB-1:0]  simg;
  logic [8:0]        bg;
  logic [AW-1:0]     rom_addr;
  logic [8:0]        rom_data = 9'h000;
  logic              hs, vs, fs;
  logic [2:0]        r, g, b;
  logic [NS-2:0]     coll;

  sprite_compositor #(
    .N_SPRITES(NS), .TILE_SIZE(TS), .IMG_BITS(IB), .TRANSPARENT(9'h000),
    .H_VISIBLE_AREA(HV), .V_VISIBLE_AREA(VV), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP)
  ) dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_Sprite_X(sx), .i_Sprite_Y(sy), .i_Sprite_En(sen), .i_Sprite_Img(simg),
    .i_Bg_Color(bg), .o_Rom_Addr(rom_addr), .i_Rom_Data(rom_data),
    .o_VGA_HSync(hs), .o_VGA_VSync(vs),
    .o_VGA_Red(r), .o_VGA_Grn(g), .o_VGA_Blu(b),
    .o_Frame_Start(fs), .o_Collision(coll)
  );

  always #5 clk = ~clk;

  // Sprite memory: returns {1,addr}, except one key address that is transparent
  function automatic logic [8:0] rom_f(input logic [7:0] a);
    return (a == TKEY) ? 9'h000 : {1'b1, a};
  endfunction
  always @(posedge clk) rom_data <= rom_f(rom_addr);

  int k;
  int checks = 0, failures = 0, fs_err = 0, fs_cnt = 0;
  logic [8:0] rgb_buf [F];
  logic       hs_buf  [F];
  logic       vs_buf  [F];

  // k = clock edges since reset release = raster position of the counters
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (k >= 3) begin
        rgb_buf[12'((k - 3) % F)] <= {r, g, b};
        hs_buf[12'((k - 3) % F)]  <= hs;
        vs_buf[12'((k - 3) % F)]  <= vs;
      end
      if (fs !== ((k > 0) && (k % F == 0))) fs_err++;
      if (fs) fs_cnt++;
    end
  end

  typedef struct packed {
    logic [3:0] cfg;
    logic [9:0] h;
    logic [9:0] v;
    logic [8:0] exp;
  } vec_t;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_k(input int target);
    int guard = 0;
    while (k < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (k < target) chk("wait_timeout", 32'(k), 32'(target));
  endtask

  task automatic frame_done();
    wait_k((k / F + 2) * F + 3);
  endtask

  function automatic logic [8:0] pix(input int h, input int v);
    return rgb_buf[12'(v * HT + h)];
  endfunction

  task automatic set_slot(input int s, input int x, input int y, input int im, input logic e);
    sx[s*10 +: 10]   = 10'(x);
    sy[s*9 +: 9]     = 9'(y);
    simg[s*IB +: IB] = 2'(im);
    sen[s]           = e;
  endtask

  task automatic apply_cfg(input int c);
    sx = '0; sy = '0; sen = '0; simg = '0;
    case (c)
      1: set_slot(0, 10, 5, 1, 1'b1);
      2: begin set_slot(0, 20, 20, 2, 1'b1); set_slot(2, 20, 20, 3, 1'b1); end
      3: begin
        set_slot(1, 44, 28, 0, 1'b1);
        set_slot(3, 1020, 2, 0, 1'b1);
        set_slot(4, 2, 508, 0, 1'b1);
      end
      default: ;
    endcase
  endtask

  task automatic check_cfg(input int c);
    for (int i = 0; i < NV; i++) begin
      if (int'(vecs[i].cfg) == c)
        chk($sformatf("pix_c%0d_(%0d,%0d)", c, vecs[i].h, vecs[i].v),
            32'(pix(int'(vecs[i].h), int'(vecs[i].v))), 32'(vecs[i].exp));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_rgb"},      32'({r, g, b}), 32'd0);
    chk({tag, "_hsync"},    32'(hs), 32'd1);
    chk({tag, "_vsync"},    32'(vs), 32'd1);
    chk({tag, "_fstart"},   32'(fs), 32'd0);
    chk({tag, "_coll"},     32'(coll), 32'd0);
  endtask

  initial begin
    int hs_low;
    vecs[0]  = '{4'd0, 10'd0,  10'd0,  BG};
    vecs[1]  = '{4'd0, 10'd47, 10'd31, BG};
    vecs[2]  = '{4'd0, 10'd48, 10'd0,  9'h000};
    vecs[3]  = '{4'd0, 10'd0,  10'd32, 9'h000};
    vecs[4]  = '{4'd0, 10'd63, 10'd39, 9'h000};
    vecs[5]  = '{4'd1, 10'd10, 10'd5,  9'h140};
    vecs[6]  = '{4'd1, 10'd17, 10'd12, 9'h17F};
    vecs[7]  = '{4'd1, 10'd12, 10'd6,  9'h14A};
    vecs[8]  = '{4'd1, 10'd13, 10'd7,  BG};
    vecs[9]  = '{4'd1, 10'd9,  10'd5,  BG};
    vecs[10] = '{4'd1, 10'd18, 10'd5,  BG};
    vecs[11] = '{4'd1, 10'd10, 10'd13, BG};
    vecs[12] = '{4'd1, 10'd10, 10'd4,  BG};
    vecs[13] = '{4'd2, 10'd20, 10'd20, 9'h180};
    vecs[14] = '{4'd2, 10'd27, 10'd27, 9'h1BF};
    vecs[15] = '{4'd2, 10'd28, 10'd20, BG};
    vecs[16] = '{4'd2, 10'd19, 10'd27, BG};
    vecs[17] = '{4'd3, 10'd44, 10'd28, 9'h100};
    vecs[18] = '{4'd3, 10'd47, 10'd31, 9'h11B};
    vecs[19] = '{4'd3, 10'd43, 10'd28, BG};
    vecs[20] = '{4'd3, 10'd48, 10'd31, 9'h000};
    vecs[21] = '{4'd3, 10'd47, 10'd32, 9'h000};
    vecs[22] = '{4'd3, 10'd0,  10'd0,  BG};
    vecs[23] = '{4'd3, 10'd3,  10'd1,  BG};
    vecs[24] = '{4'd3, 10'd1,  10'd3,  BG};
    vecs[25] = '{4'd3, 10'd7,  10'd7,  BG};

    bg = BG;
    apply_cfg(0);
    #1 rst = 1'b1;
    #1 check_reset_vals("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Empty scene plus sync placement
    frame_done();
    check_cfg(0);
    chk("hs_51", 32'(hs_buf[51]), 32'd1);
    chk("hs_52", 32'(hs_buf[52]), 32'd0);
    chk("hs_59", 32'(hs_buf[59]), 32'd0);
    chk("hs_60", 32'(hs_buf[60]), 32'd1);
    hs_low = 0;
    for (int h = 0; h < int'(HT); h++) if (!hs_buf[12'(5 * HT + h)]) hs_low++;
    chk("hs_low_count", 32'(hs_low), 32'd8);
    chk("vs_33", 32'(vs_buf[12'(33 * HT)]), 32'd1);
    chk("vs_34", 32'(vs_buf[12'(34 * HT)]), 32'd0);
    chk("vs_35", 32'(vs_buf[12'(35 * HT + 63)]), 32'd0);
    chk("vs_36", 32'(vs_buf[12'(36 * HT)]), 32'd1);

    // Player sprite image addressing and transparency
    apply_cfg(1);
    frame_done();
    check_cfg(1);

    // Mid-frame move must not tear
    wait_k((k / F) * F + 200);
    set_slot(0, 30, 5, 1, 1'b1);
    wait_k((k / F + 1) * F + 3);
    chk("tear_old_10_5", 32'(pix(10, 5)), 32'h140);
    chk("tear_old_30_5", 32'(pix(30, 5)), 32'(BG));
    wait_k((k / F + 1) * F + 3);
    chk("moved_30_5", 32'(pix(30, 5)), 32'h140);
    chk("moved_37_12", 32'(pix(37, 12)), 32'h17F);
    chk("moved_10_5", 32'(pix(10, 5)), 32'(BG));

    // Edge-crossing sprites, no wrap-around
    apply_cfg(3);
    frame_done();
    check_cfg(3);
    chk("coll_none", 32'(coll), 32'd0);

    // Priority and collision reporting
    apply_cfg(2);
    frame_done();
    check_cfg(2);
    chk("coll_set", 32'(coll), 32'h2);
    set_slot(2, 40, 0, 3, 1'b1);
    wait_k((k / F + 1) * F + 3);
    chk("coll_hold", 32'(coll), 32'h2);
    wait_k((k / F + 1) * F + 3);
    chk("coll_clear", 32'(coll), 32'h0);
    chk("slot2_moved_40_0", 32'(pix(40, 0)), 32'h1C0);
    chk("slot0_20_20", 32'(pix(20, 20)), 32'h180);

    // Asynchronous mid-line reset
    set_slot(2, 20, 20, 3, 1'b1);
    frame_done();
    chk("coll_pre_reset", 32'(coll), 32'h2);
    wait_k((k / F) * F + 20 * HT + 22);
    rst = 1'b1;
    #1 check_reset_vals("midline");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_k(F + 3);
    chk("post_rst_20_20", 32'(pix(20, 20)), 32'(BG));
    chk("post_rst_0_0", 32'(pix(0, 0)), 32'(BG));
    chk("post_rst_48_0", 32'(pix(48, 0)), 32'd0);
    wait_k(2 * F + 3);
    chk("post_rst2_20_20", 32'(pix(20, 20)), 32'h180);

    chk("frame_start_timing", 32'(fs_err), 32'd0);
    chk("frame_start_seen", 32'(fs_cnt > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
